// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: register offsets, CTRL/STATUS bit positions and reset
// constants shared by the mmio_timer top level and the bench.
package mmio_timer_pkg;

  // Byte offsets of the registers within the 32-byte window
  localparam logic [4:0] TMR_CTRL     = 5'h00;
  localparam logic [4:0] TMR_PRESCALE = 5'h04;
  localparam logic [4:0] TMR_COUNT    = 5'h08;
  localparam logic [4:0] TMR_COMPARE  = 5'h0C;
  localparam logic [4:0] TMR_STATUS   = 5'h10;

  // CTRL bit positions (OIE only exists with the overflow feature)
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_OIE    = 3;

  // STATUS bit positions (OVF only exists with the overflow feature)
  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

  // COMPARE comes out of reset at the far end of the count range
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer_prescaler.sv
// mmio_timer_prescaler: divides clk by (prescale+1) while enabled.
// tick is high in the cycle where the counter equals prescale; the counter
// restarts from 0 on that cycle and whenever clr is pulsed.
module mmio_timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt_reg;

  // Tick is judged against the current PRESCALE value; a clr in the same
  // cycle only restarts the count for the following period.
  assign tick = en && (pcnt_reg == prescale);

  // Prescale counter: cleared by clr, frozen while disabled, wraps on tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_reg <= '0;
    end else if (clr) begin
      pcnt_reg <= '0;
    end else if (en) begin
      if (tick) pcnt_reg <= '0;
      else      pcnt_reg <= pcnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit up-counter with compare match,
// sticky W1C status flags and a level interrupt. Responds on the CPU data
// memory bus with combinational reads and clock-edge writes.
// Optional build macro: MMIO_TIMER_OVF_EN adds STATUS.OVF and CTRL.OIE.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] DM_rdata,
  output logic        irq
);

  logic                  ctrl_en_reg;
  logic                  ctrl_reload_reg;
  logic                  ctrl_ie_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [31:0]           count_reg;
  logic [31:0]           compare_reg;
  logic                  match_reg;
  logic                  oie_bit;
  logic                  ovf_bit;

  logic        hit;
  logic        wr;
  logic [4:0]  reg_off;
  logic        tick;
  logic        prescale_wr;
  logic        count_wr;
  logic        status_w1c;
  logic [31:0] count_next;
  logic        match_set;

  // Byte-lane bits are ignored; the register is selected by word index
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, DM_addr[1:0]};

  assign hit         = DM_CS && (DM_addr[31:5] == BASE_ADDR[31:5]);
  assign wr          = hit && DM_W;
  assign reg_off     = {DM_addr[4:2], 2'b00};
  assign prescale_wr = wr && (reg_off == TMR_PRESCALE);
  assign count_wr    = wr && (reg_off == TMR_COUNT);
  assign status_w1c  = wr && (reg_off == TMR_STATUS);

  mmio_timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (ctrl_en_reg),
    .prescale(prescale_reg),
    .clr     (prescale_wr),
    .tick    (tick)
  );

  // A bus write to COUNT overrides the tick, so no match is judged that cycle
  assign count_next = count_reg + 32'd1;
  assign match_set  = tick && !count_wr && (count_next == compare_reg);

  // Control, prescale, compare, counter and MATCH flag (set wins over W1C)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en_reg     <= 1'b0;
      ctrl_reload_reg <= 1'b0;
      ctrl_ie_reg     <= 1'b0;
      prescale_reg    <= '0;
      count_reg       <= '0;
      compare_reg     <= COMPARE_RST;
      match_reg       <= 1'b0;
    end else begin
      if (wr && (reg_off == TMR_CTRL)) begin
        ctrl_en_reg     <= DM_wdata[CTRL_EN];
        ctrl_reload_reg <= DM_wdata[CTRL_RELOAD];
        ctrl_ie_reg     <= DM_wdata[CTRL_IE];
      end
      if (prescale_wr) prescale_reg <= DM_wdata[PRESCALE_W-1:0];
      if (wr && (reg_off == TMR_COMPARE)) compare_reg <= DM_wdata;
      if (count_wr) begin
        count_reg <= DM_wdata;
      end else if (tick) begin
        count_reg <= (match_set && ctrl_reload_reg) ? 32'd0 : count_next;
      end
      match_reg <= match_set | (match_reg & ~(status_w1c & DM_wdata[STAT_MATCH]));
    end
  end

`ifdef MMIO_TIMER_OVF_EN
  logic oie_reg;
  logic ovf_reg;
  logic ovf_set;

  // Overflow is the natural wrap from all-ones; a reload to 0 does not count
  assign ovf_set = tick && !count_wr && (count_reg == 32'hFFFF_FFFF);

  // OIE enable and OVF flag (set wins over W1C)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oie_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      if (wr && (reg_off == TMR_CTRL)) oie_reg <= DM_wdata[CTRL_OIE];
      ovf_reg <= ovf_set | (ovf_reg & ~(status_w1c & DM_wdata[STAT_OVF]));
    end
  end

  assign oie_bit = oie_reg;
  assign ovf_bit = ovf_reg;
`else
  assign oie_bit = 1'b0;
  assign ovf_bit = 1'b0;
`endif

  // Level interrupt straight from the registered flags and enables
  assign irq = (match_reg && ctrl_ie_reg) || (ovf_bit && oie_bit);

  // Combinational read mux; zero whenever this block is not being read
  always_comb begin
    DM_rdata = 32'h0;
    if (hit && DM_R) begin
      case (reg_off)
        TMR_CTRL:     DM_rdata = {28'h0, oie_bit, ctrl_ie_reg, ctrl_reload_reg, ctrl_en_reg};
        TMR_PRESCALE: DM_rdata = 32'(prescale_reg);
        TMR_COUNT:    DM_rdata = count_reg;
        TMR_COMPARE:  DM_rdata = compare_reg;
        TMR_STATUS:   DM_rdata = {30'h0, ovf_bit, match_reg};
        default:      DM_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scoreboard bench for mmio_timer. Each test task pushes the
// values it expects, drives the bus, then pops and compares the DUT output.
module tb_mmio_timer;

  localparam logic [31:0] A_CTRL     = 32'h0000_4000;
  localparam logic [31:0] A_PRESCALE = 32'h0000_4004;
  localparam logic [31:0] A_COUNT    = 32'h0000_4008;
  localparam logic [31:0] A_COMPARE  = 32'h0000_400C;
  localparam logic [31:0] A_STATUS   = 32'h0000_4010;

  logic        clk;
  logic        rst;
  logic        DM_CS;
  logic        DM_R;
  logic        DM_W;
  logic [31:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [31:0] DM_rdata;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_cyc;
  int          rd_cyc;
  logic [31:0] rd_data;
  logic        rd_irq;

  mmio_timer #(
    .BASE_ADDR (32'h0000_4000),
    .PRESCALE_W(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .DM_CS   (DM_CS),
    .DM_R    (DM_R),
    .DM_W    (DM_W),
    .DM_addr (DM_addr),
    .DM_wdata(DM_wdata),
    .DM_rdata(DM_rdata),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ops start and end at a negedge; a read samples state after the last posedge
  task automatic bus_read(input logic [31:0] addr);
    DM_CS = 1'b1; DM_R = 1'b1; DM_W = 1'b0; DM_addr = addr;
    #2;
    rd_data = DM_rdata; rd_irq = irq; rd_cyc = cyc;
    DM_CS = 1'b0; DM_R = 1'b0;
    @(negedge clk);
  endtask

  // A write commits on the posedge that follows the starting negedge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    DM_CS = 1'b1; DM_W = 1'b1; DM_R = 1'b0; DM_addr = addr; DM_wdata = data;
    @(posedge clk);
    #1;
    wr_cyc = cyc;
    DM_CS = 1'b0; DM_W = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [31:0] addrs [7] = '{A_CTRL, A_PRESCALE, A_COUNT, A_COMPARE, A_STATUS,
                               32'h0000_4014, 32'h0000_0100};
    exp_t e;
    push("rst_ctrl", 32'h0); push("rst_prescale", 32'h0); push("rst_count", 32'h0);
    push("rst_compare", 32'hFFFF_FFFF); push("rst_status", 32'h0);
    push("reserved", 32'h0); push("unmapped", 32'h0);
    for (int i = 0; i < 7; i++) begin
      bus_read(addrs[i]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.val) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, rd_data, e.val);
      end else $display("ok   %s = %h", e.name, rd_data);
    end
    checks++;
    if (rd_irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_irq got %b want 0", rd_irq);
    end
    // Selected but no read strobe must return zero
    DM_CS = 1'b1; DM_addr = A_COMPARE; #2;
    checks++;
    if (DM_rdata !== 32'h0) begin
      errors++;
      $display("FAIL no_rd_strobe got %h want 0", DM_rdata);
    end else $display("ok   no_rd_strobe = %h", DM_rdata);
    DM_CS = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ctrl_mask();
    exp_t e;
`ifdef MMIO_TIMER_OVF_EN
    push("ctrl_mask", 32'h8);
`else
    push("ctrl_mask", 32'h0);
`endif
    push("count_idle", 32'h0);
    bus_write(A_CTRL, 32'hFFFF_FFF8);
    bus_read(A_CTRL);
    e = exp_q.pop_front(); checks++;
    if (rd_data !== e.val) begin
      errors++; $display("FAIL %s got %h want %h", e.name, rd_data, e.val);
    end else $display("ok   %s = %h", e.name, rd_data);
    bus_read(A_COUNT);
    e = exp_q.pop_front(); checks++;
    if (rd_data !== e.val) begin
      errors++; $display("FAIL %s got %h want %h", e.name, rd_data, e.val);
    end else $display("ok   %s = %h", e.name, rd_data);
    bus_write(A_CTRL, 32'h0);
  endtask

  // Poll STATUS.MATCH each cycle; returns cycle index of first set sample
  task automatic poll_match(output int hit_cyc, output logic hit_irq, output bit found);
    found = 0; hit_cyc = 0; hit_irq = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      bus_read(A_STATUS);
      if (rd_data[0]) begin
        found = 1; hit_cyc = rd_cyc; hit_irq = rd_irq;
      end
    end
  endtask

  task automatic test_match_and_w1c();
    int   en_cyc, first_cyc, second_cyc;
    logic hirq;
    bit   found;
    exp_t e;
    push("match_delay", 32'd20); push("match_irq", 32'd1); push("count_after_reload", 32'd0);
    push("w1c_status", 32'd0);   push("w1c_irq", 32'd0);   push("match_period", 32'd20);
    push("setwins_status", 32'd1); push("setwins_irq", 32'd1);
    bus_write(A_PRESCALE, 32'd3);
    bus_write(A_COMPARE, 32'd5);
    bus_write(A_CTRL, 32'h7);
    en_cyc = wr_cyc;
    poll_match(first_cyc, hirq, found);
    e = exp_q.pop_front(); checks++;
    if (!found || (first_cyc - en_cyc) != int'(e.val)) begin
      errors++; $display("FAIL %s got %0d (found=%0d) want %0d", e.name, first_cyc - en_cyc, found, e.val);
    end else $display("ok   %s = %0d", e.name, first_cyc - en_cyc);
    e = exp_q.pop_front(); checks++;
    if (hirq !== e.val[0]) begin
      errors++; $display("FAIL %s got %b want %b", e.name, hirq, e.val[0]);
    end else $display("ok   %s = %b", e.name, hirq);
    bus_read(A_COUNT);
    e = exp_q.pop_front(); checks++;
    if (rd_data !== e.val) begin
      errors++; $display("FAIL %s got %h want %h", e.name, rd_data, e.val);
    end else $display("ok   %s = %h", e.name, rd_data);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS);
    e = exp_q.pop_front(); checks++;
    if (rd_data !== e.val) begin
      errors++; $display("FAIL %s got %h want %h", e.name, rd_data, e.val);
    end else $display("ok   %s = %h", e.name, rd_data);
    e = exp_q.pop_front(); checks++;
    if (rd_irq !== e.val[0]) begin
      errors++; $display("FAIL %s got %b want %b", e.name, rd_irq, e.val[0]);
    end else $display("ok   %s = %b", e.name, rd_irq);
    poll_match(second_cyc, hirq, found);
    e = exp_q.pop_front(); checks++;
    if (!found || (second_cyc - first_cyc) != int'(e.val)) begin
      errors++; $display("FAIL %s got %0d (found=%0d) want %0d", e.name, second_cyc - first_cyc, found, e.val);
    end else $display("ok   %s = %0d", e.name, second_cyc - first_cyc);
    bus_write(A_STATUS, 32'h1);
    // Land a W1C exactly on the next match edge
    while (cyc < second_cyc + 19) @(negedge clk);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS);
    e = exp_q.pop_front(); checks++;
    if (rd_data !== e.val || wr_cyc != second_cyc + 20) begin
      errors++; $display("FAIL %s got %h at cyc %0d want %h at cyc %0d", e.name, rd_data, wr_cyc, e.val, second_cyc + 20);
    end else $display("ok   %s = %h", e.name, rd_data);
    e = exp_q.pop_front(); checks++;
    if (rd_irq !== e.val[0]) begin
      errors++; $display("FAIL %s got %b want %b", e.name, rd_irq, e.val[0]);
    end else $display("ok   %s = %b", e.name, rd_irq);
  endtask

  task automatic test_count_write_wins();
    logic [31:0] addrs [3] = '{A_COUNT, A_COUNT, A_STATUS};
    exp_t e;
    push("cw_written", 32'h10); push("cw_next", 32'h11); push("cw_no_match", 32'h0);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_PRESCALE, 32'h0);
    bus_write(A_COMPARE, 32'h10);
    bus_write(A_COUNT, 32'h0);
    bus_write(A_STATUS, 32'h3);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_COUNT, 32'h10);
    for (int i = 0; i < 3; i++) begin
      bus_read(addrs[i]);
      e = exp_q.pop_front(); checks++;
      if (rd_data !== e.val) begin
        errors++; $display("FAIL %s got %h want %h", e.name, rd_data, e.val);
      end else $display("ok   %s = %h", e.name, rd_data);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    push("wrap0", 32'hFFFF_FFFE); push("wrap1", 32'hFFFF_FFFF); push("wrap2", 32'h0);
    push("wrap3", 32'h1);         push("wrap4", 32'h2);         push("wrap5", 32'h3);
`ifdef MMIO_TIMER_OVF_EN
    push("wrap_status", 32'h3);
`else
    push("wrap_status", 32'h1);
`endif
    bus_write(A_CTRL, 32'h0);
    bus_write(A_COMPARE, 32'h3);
    bus_write(A_COUNT, 32'hFFFF_FFFE);
    bus_write(A_STATUS, 32'h3);
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) begin
      bus_read(A_COUNT);
      e = exp_q.pop_front(); checks++;
      if (rd_data !== e.val) begin
        errors++; $display("FAIL %s got %h want %h", e.name, rd_data, e.val);
      end else $display("ok   %s = %h", e.name, rd_data);
    end
    bus_read(A_STATUS);
    e = exp_q.pop_front(); checks++;
    if (rd_data !== e.val) begin
      errors++; $display("FAIL %s got %h want %h", e.name, rd_data, e.val);
    end else $display("ok   %s = %h", e.name, rd_data);
  endtask

  task automatic test_async_reset();
    logic [31:0] addrs [5] = '{A_CTRL, A_PRESCALE, A_COUNT, A_COMPARE, A_STATUS};
    exp_t e;
    push("pre_rst_irq", 32'h1); push("async_irq", 32'h0); push("async_rdata", 32'h0);
    push("ar_ctrl", 32'h0); push("ar_prescale", 32'h0); push("ar_count", 32'h0);
    push("ar_compare", 32'hFFFF_FFFF); push("ar_status", 32'h0);
    bus_write(A_PRESCALE, 32'h5);
    bus_write(A_CTRL, 32'h5);
    bus_read(A_STATUS);
    e = exp_q.pop_front(); checks++;
    if (rd_irq !== e.val[0]) begin
      errors++; $display("FAIL %s got %b want %b", e.name, rd_irq, e.val[0]);
    end else $display("ok   %s = %b", e.name, rd_irq);
    // Start a COUNT write, then assert reset before its clock edge
    DM_CS = 1'b1; DM_W = 1'b1; DM_R = 1'b1; DM_addr = A_COUNT; DM_wdata = 32'h1234;
    #1 rst = 1'b1;
    #1;
    e = exp_q.pop_front(); checks++;
    if (irq !== e.val[0]) begin
      errors++; $display("FAIL %s got %b want %b", e.name, irq, e.val[0]);
    end else $display("ok   %s = %b", e.name, irq);
    e = exp_q.pop_front(); checks++;
    if (DM_rdata !== e.val) begin
      errors++; $display("FAIL %s got %h want %h", e.name, DM_rdata, e.val);
    end else $display("ok   %s = %h", e.name, DM_rdata);
    @(posedge clk);
    #2;
    rst = 1'b0;
    DM_CS = 1'b0; DM_W = 1'b0; DM_R = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus_read(addrs[i]);
      e = exp_q.pop_front(); checks++;
      if (rd_data !== e.val) begin
        errors++; $display("FAIL %s got %h want %h", e.name, rd_data, e.val);
      end else $display("ok   %s = %h", e.name, rd_data);
    end
  endtask

  initial begin
    rst = 1'b1; DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
    DM_addr = 32'h0; DM_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_ctrl_mask();
    test_match_and_w1c();
    test_count_write_wins();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
